// File: rtl/seg7_frame_capture.sv
// Snoops a multiplexed active-low seven-segment bus, decodes each stable digit
// back to hex and publishes one NUM_DIGITS-nibble frame on a valid/ready port.
module seg7_frame_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    overrun
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SMP_W  = 7 + NUM_DIGITS;
    localparam int unsigned WORD_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t state, state_n;

    logic [SMP_W-1:0]      smp;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  match, onehot, commit;
    logic [3:0]            dec_nib;
    logic                  dec_err, dec_blank;
    logic [WORD_W-1:0]     slot_word, slot_word_n;
    logic [NUM_DIGITS-1:0] slot_err, slot_err_n;
    logic [NUM_DIGITS-1:0] slot_blank, slot_blank_n;
    logic [NUM_DIGITS-1:0] seen, seen_acc, seen_n, wr;
    logic                  complete, handshake, load_frame, set_overrun;

    // Run-length tracking of the raw {seg, dig_en} bus value
    assign match  = ({seg, dig_en} == smp);
    assign onehot = (dig_en != '0) && ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);

    always_comb begin
        cnt_n = cnt;
        if (!match) begin
            cnt_n = CNT_W'(1);
        end else if (cnt >= CNT_MAX) begin
            cnt_n = CNT_MAX;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    // Only the edge where the run reaches the threshold commits, so one commit per run
    assign commit = match && onehot && (cnt == (CNT_MAX - CNT_W'(1)));

    // Inverse of the encoder table; seg bit6..bit0 = g..a
    always_comb begin
        dec_nib   = 4'h0;
        dec_err   = 1'b0;
        dec_blank = 1'b0;
        case (seg)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0011000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Per-digit slot write on commit
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
        assign wr[g]                  = commit & dig_en[g];
        assign slot_word_n[4*g +: 4]  = wr[g] ? dec_nib   : slot_word[4*g +: 4];
        assign slot_err_n[g]          = wr[g] ? dec_err   : slot_err[g];
        assign slot_blank_n[g]        = wr[g] ? dec_blank : slot_blank[g];
    end

    assign seen_acc = seen | wr;
    assign complete = commit & (&seen_acc);
    assign seen_n   = complete ? '0 : seen_acc;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            smp        <= '0;
            cnt        <= '0;
            slot_word  <= '0;
            slot_err   <= '0;
            slot_blank <= '0;
            seen       <= '0;
        end else begin
            smp        <= {seg, dig_en};
            cnt        <= cnt_n;
            slot_word  <= slot_word_n;
            slot_err   <= slot_err_n;
            slot_blank <= slot_blank_n;
            seen       <= seen_n;
        end
    end

    assign handshake = word_valid & word_ready;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    // Publish control; collection keeps running while a frame is held
    always_comb begin
        state_n     = state;
        load_frame  = 1'b0;
        set_overrun = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    load_frame = 1'b1;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (handshake && complete) begin
                    load_frame = 1'b1;
                end else if (handshake) begin
                    state_n = COLLECT;
                end else if (complete) begin
                    set_overrun = 1'b1;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            digit_err  <= '0;
            blank      <= '0;
            overrun    <= 1'b0;
        end else begin
            word_valid <= (state_n == HOLD);
            if (load_frame) begin
                word_out  <= slot_word_n;
                digit_err <= slot_err_n;
                blank     <= slot_blank_n;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
